// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath (ld, sd, R-type, beq; anything else traps).
// Latency: R-type 4, ld 5, sd 4, beq 3 cycles, plus one cycle per memory wait cycle.
// Backpressure: mem_read/mem_write stay asserted until mem_ready; reset drops any request in the same cycle.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        old_pc_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_source,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t      r_state;
    logic [12:0] r_moore;
    logic [31:0] r_instret;
    state_t      w_next;
    logic        w_retire;
    logic [12:0] w_moore_gated;

    // Moore control word for a state:
    // {mem_read, mem_write, i_or_d, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal}
    function automatic logic [12:0] f_moore(input state_t s);
        logic [12:0] v;
        v = '0;
        case (s)
            S_FETCH:    v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
            S_DECODE:   v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
            S_MEM_ADDR: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
            S_MEM_RD:   v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            S_MEM_WB:   v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            S_MEM_WR:   v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            S_R_EXEC:   v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
            S_R_WB:     v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            S_BRANCH:   v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
            S_TRAP:     v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
            default:    v = '0;
        endcase
        return v;
    endfunction

    // Next-state selection and retire detection; mem_ready only matters in the three memory states
    always_comb begin
        w_next   = S_TRAP;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LD || opcode == OP_SD) w_next = S_MEM_ADDR;
                else if (opcode == OP_R)                w_next = S_R_EXEC;
                else if (opcode == OP_BEQ)              w_next = S_BRANCH;
                else                                    w_next = S_TRAP;
            end
            S_MEM_ADDR: w_next = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEM_WR: begin
                w_next   = mem_ready ? S_FETCH : S_MEM_WR;
                w_retire = mem_ready;
            end
            S_R_EXEC:   w_next = S_R_WB;
            S_R_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    // State, registered Moore controls (decoded from the state being entered) and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_moore   <= f_moore(S_FETCH);
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_moore <= f_moore(w_next);
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // Reset masks every control output immediately so no request leaks while it is held
    assign w_moore_gated = r_moore & {13{~reset}};
    assign {mem_read, mem_write, i_or_d, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_source, illegal} = w_moore_gated;

    // Fetch-complete strobes follow mem_ready; branch PC load follows the ALU zero flag
    assign ir_write     = ~reset & (r_state == S_FETCH) & mem_ready;
    assign old_pc_write = ir_write;
    assign pc_write     = ~reset & (((r_state == S_FETCH) & mem_ready) |
                                    ((r_state == S_BRANCH) & zero));

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/controls/instret queued then compared.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, old_pc_write, i_or_d, mem_read, mem_write;
    logic        mem_to_reg, reg_write, pc_source, illegal;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] instret;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [31:0] ir;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] n_ret = '0;

    multicycle_control dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .old_pc_write (old_pc_write),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected controls per state from the output table:
    // {pc_write, ir_write, old_pc_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
    //  alu_src_a, alu_src_b, alu_op, pc_source, illegal}
    function automatic logic [15:0] exp_ctl(input int s, input bit mr, input bit z);
        logic pw, irw, opw, iod, mrd, mwr, m2r, rw, pcs, ill;
        logic [1:0] sa, sbb, aop;
        {pw, irw, opw, iod, mrd, mwr, m2r, rw, pcs, ill} = '0;
        sa = 2'b00; sbb = 2'b00; aop = 2'b00;
        case (s)
            0: begin mrd = 1'b1; sbb = 2'b01; pw = mr; irw = mr; opw = mr; end
            1: begin sa = 2'b01; sbb = 2'b10; end
            2: begin sa = 2'b10; sbb = 2'b10; end
            3: begin mrd = 1'b1; iod = 1'b1; end
            4: begin rw = 1'b1; m2r = 1'b1; end
            5: begin mwr = 1'b1; iod = 1'b1; end
            6: begin sa = 2'b10; sbb = 2'b00; aop = 2'b10; end
            7: begin rw = 1'b1; end
            8: begin sa = 2'b10; sbb = 2'b00; aop = 2'b01; pcs = 1'b1; pw = z; end
            9: begin ill = 1'b1; end
            default: ;
        endcase
        return {pw, irw, opw, iod, mrd, mwr, m2r, rw, sa, sbb, aop, pcs, ill};
    endfunction

    // One clock cycle: queue the expectation, drive inputs, compare at the falling edge, advance
    task automatic cyc(input string tag, input bit rst, input bit mr, input bit z,
                       input logic [6:0] op, input int st);
        exp_t e, got;
        e.tag = tag;
        e.st  = st[3:0];
        e.ctl = rst ? 16'h0000 : exp_ctl(st, mr, z);
        e.ir  = n_ret;
        sb.push_back(e);
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        @(negedge clk);
        got = sb.pop_front();
        check({got.tag, "_state"}, {28'd0, state}, {28'd0, got.st});
        check({got.tag, "_ctl"}, {16'd0, pc_write, ir_write, old_pc_write, i_or_d, mem_read,
              mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
              illegal}, {16'd0, got.ctl});
        check({got.tag, "_instret"}, instret, got.ir);
        @(posedge clk);
        #1;
    endtask

    task automatic run_rtype(input string tag);
        cyc({tag, "_F"}, 0, 1, 0, OP_R, 0);
        cyc({tag, "_D"}, 0, 0, 0, OP_R, 1);
        cyc({tag, "_EX"}, 0, 0, 0, OP_R, 6);
        cyc({tag, "_WB"}, 0, 0, 0, OP_R, 7);
        n_ret = n_ret + 32'd1;
    endtask

    task automatic run_beq(input string tag, input bit z);
        cyc({tag, "_F"}, 0, 1, z, OP_BEQ, 0);
        cyc({tag, "_D"}, 0, 0, z, OP_BEQ, 1);
        cyc({tag, "_BR"}, 0, 0, z, OP_BEQ, 8);
        n_ret = n_ret + 32'd1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset held with mem_ready high: nothing escapes, state and counter cleared
        for (int i = 0; i < 3; i++) cyc("rst", 1, 1, 1, OP_R, 0);

        // First cycle after release fetches; R-type completes in 4 cycles
        run_rtype("rtype");

        // ld with two wait cycles in MEM_RD: 7 cycles total
        cyc("ld_F", 0, 1, 0, OP_LD, 0);
        cyc("ld_D", 0, 0, 0, OP_LD, 1);
        cyc("ld_MA", 0, 0, 0, OP_LD, 2);
        cyc("ld_RDw0", 0, 0, 0, OP_LD, 3);
        cyc("ld_RDw1", 0, 0, 0, OP_LD, 3);
        cyc("ld_RD", 0, 1, 0, OP_LD, 3);
        cyc("ld_WB", 0, 0, 0, OP_LD, 4);
        n_ret = n_ret + 32'd1;

        // beq taken and not taken both retire
        run_beq("beq_t", 1);
        run_beq("beq_nt", 0);

        // sd with one fetch wait and one write wait; retires on the ready cycle
        cyc("sd_Fw", 0, 0, 0, OP_SD, 0);
        cyc("sd_F", 0, 1, 0, OP_SD, 0);
        cyc("sd_D", 0, 0, 0, OP_SD, 1);
        cyc("sd_MA", 0, 0, 0, OP_SD, 2);
        cyc("sd_WRw", 0, 0, 0, OP_SD, 5);
        cyc("sd_WR", 0, 1, 0, OP_SD, 5);
        n_ret = n_ret + 32'd1;

        // Illegal opcode traps and stays trapped without retiring; mem_ready ignored there
        cyc("ill_F", 0, 1, 0, OP_BAD, 0);
        cyc("ill_D", 0, 0, 0, OP_BAD, 1);
        for (int i = 0; i < 12; i++) cyc("ill_TRAP", 0, (i % 2) == 1, (i % 3) == 0, OP_BAD, 9);
        cyc("ill_rst", 1, 0, 0, OP_BAD, 9);
        n_ret = '0;
        cyc("ill_exit", 0, 1, 0, OP_R, 0);
        cyc("ill_exit_D", 0, 0, 0, OP_R, 1);
        cyc("ill_exit_EX", 0, 0, 0, OP_R, 6);
        cyc("ill_exit_WB", 0, 0, 0, OP_R, 7);
        n_ret = n_ret + 32'd1;

        // Reset in the middle of an sd wait: write request drops at once, nothing retires
        cyc("sdr_F", 0, 1, 0, OP_SD, 0);
        cyc("sdr_D", 0, 0, 0, OP_SD, 1);
        cyc("sdr_MA", 0, 0, 0, OP_SD, 2);
        cyc("sdr_WRw", 0, 0, 0, OP_SD, 5);
        cyc("sdr_rst", 1, 0, 0, OP_SD, 5);
        n_ret = '0;
        cyc("sdr_after", 1, 0, 0, OP_SD, 0);

        // Counter wrap: preload all-ones, next retire returns it to zero
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        n_ret = 32'hFFFF_FFFF;
        run_rtype("wrap");
        cyc("wrap_F", 0, 0, 0, OP_R, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RISC-V datapath. It decodes the instruction opcode, sequences fetch, decode, execute, memory and write-back over several cycles, and drives every datapath enable and mux select. It produces the 2-bit `alu_op` consumed by the ALU control decoder (00 add, 01 subtract/compare, 10 R-type funct decode). It waits on a single-bit memory-ready handshake and counts retired instructions.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 7: `IR[6:0]` from the instruction register; valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: instruction register load enable.
- `old_pc_write` out 1: old-PC register load, same timing as `ir_write`.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request; held until `mem_ready`.
- `mem_write` out 1: memory write request; held until `mem_ready`.
- `mem_to_reg` out 1: write-back data select; 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 00 PC, 01 oldPC, 10 register A.
- `alu_src_b` out 2: 00 register B, 01 constant 4, 10 immediate.
- `alu_op` out 2: to ALU control decoder.
- `pc_source` out 1: 0 = ALU result, 1 = ALUOut.
- `illegal` out 1: high while in TRAP.
- `state` out 4: current state encoding, for debug.
- `instret` out 32: retired-instruction counter.

## Operation
- Supported opcodes:
  - `ld` 0000011
  - `sd` 0100011
  - R-type 0110011
  - `beq` 1100011
  - Any other opcode in DECODE goes to TRAP.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, TRAP=9.
- Moore outputs per state. Any output not listed is 0; `alu_src_*` and `alu_op` are 00 when not listed.
  - **FETCH:** `mem_read`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `pc_source`=0. `ir_write`, `old_pc_write` and `pc_write` equal `mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when `mem_ready`=1.
  - **DECODE:** `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00 (branch target into ALUOut). Next state by opcode: `ld` or `sd` → MEM_ADDR, R-type → R_EXEC, `beq` → BRANCH, other → TRAP.
  - **MEM_ADDR:** `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00. Next: `ld` → MEM_RD, `sd` → MEM_WR.
  - **MEM_RD:** `mem_read`=1, `i_or_d`=1. Wait for `mem_ready`, then go to MEM_WB.
  - **MEM_WB:** `reg_write`=1, `mem_to_reg`=1. Go to FETCH; retire.
  - **MEM_WR:** `mem_write`=1, `i_or_d`=1. Wait for `mem_ready`, then go to FETCH; retire on the `mem_ready` cycle.
  - **R_EXEC:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Go to R_WB.
  - **R_WB:** `reg_write`=1, `mem_to_reg`=0. Go to FETCH; retire.
  - **BRANCH:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `pc_source`=1. `pc_write` = `zero` (combinational, this cycle only). Go to FETCH; retire regardless of branch outcome.
  - **TRAP:** `illegal`=1, all enables 0. Absorbing; only `reset` exits.
- `instret`:
  - Increments by 1 on each retire edge.
  - Wraps from FFFF_FFFF to 0.
  - Does not count the TRAP instruction.

## Timing
- Reset:
  - While `reset`=1, all outputs except `state` and `instret` are forced to 0 combinationally. No memory request escapes during reset.
  - On the clock edge with `reset`=1: `state` ← FETCH (0) and `instret` ← 0.
  - The first FETCH request appears on the cycle after `reset` deasserts.
- Reset asserted mid-access (e.g. in MEM_RD with `mem_ready`=0) drops `mem_read`/`mem_write` in the same cycle. The access is abandoned and does not retire.
- `mem_ready` is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored in all other states.
- Request signals stay asserted through every wait cycle. Memory must not return `mem_ready` without a request.
- Latency, in cycles, with `mem_ready` high on the first request cycle:
  - R-type: 4.
  - `ld`: 5.
  - `sd`: 4.
  - `beq`: 3.
  - Each wait cycle adds 1.
- Retire and the transition back to FETCH occur on the same edge.
- `pc_write` in FETCH and in BRANCH can never overlap, since they are in different states.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles with `mem_ready`=1 → all enables 0, `state`=0, `instret`=0. On the first cycle after release, `mem_read`=1 and `alu_src_b`=01.
- **R-type, no wait:** opcode 0110011 → states 0,1,6,7,0. `alu_op`=10 in R_EXEC. `reg_write`=1 and `mem_to_reg`=0 in R_WB. `instret`=1 after 4 cycles.
- **`ld` with 2 wait cycles in MEM_RD:** opcode 0000011 → `mem_read` with `i_or_d`=1 is held 3 cycles. `reg_write` and `mem_to_reg`=1 on the next cycle. Total 7 cycles.
- **`beq`, both outcomes:** opcode 1100011 with `zero`=1 → `pc_write`=1, `pc_source`=1, `alu_op`=01 in BRANCH. With `zero`=0 → `pc_write`=0. `instret` increments in both cases.
- **Illegal opcode:** 1111111 → TRAP (state 9), `illegal`=1 held for 10+ cycles, `instret` unchanged. Asserting `reset` then returns to FETCH.
- **Reset during `sd` wait and counter wrap:** reset in MEM_WR with `mem_ready`=0 → `mem_write` drops that cycle and `instret` stays 0. Separately, force `instret` to FFFF_FFFF via a back-to-back sequence or force → wraps to 0 on the next retire.
